lab9_soc_from_hw_sig: RTL and testbench

Avalon-MM slave input PIO carrying hardware status signals (e.g. AES `done`) back to the Nios II. It is the hardware-to-software counterpart of the software-to-hardware signal port. It synchronises an asynchronous input bus, latches selected edges into a sticky capture register, and raises a maskable interrupt. Software polls or services the interrupt through a 4-word register window on the system interconnect.

---
 rtl/lab9_soc_pio_pkg.sv | 31 +++
 rtl/lab9_soc_sig_sync.sv | 30 +++
 rtl/lab9_soc_from_hw_sig.sv | 124 ++++++++++++
 tb/tb_lab9_soc_from_hw_sig.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab9_soc_pio_pkg.sv
// Purpose: shared definitions for the lab9 SoC PIO blocks (register map, edge types, bus word).
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package lab9_soc_pio_pkg;

  // Word addresses inside the 4-word register window.
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  typedef logic [31:0] data_word_t;

  // One-bit edge detector: cur is the synchronised value, prv the same value one cycle older.
  function automatic logic edge_detect(input edge_type_e kind, input logic cur, input logic prv);
    logic hit;
    case (kind)
      EDGE_RISE: hit = cur & ~prv;
      EDGE_FALL: hit = ~cur & prv;
      default:   hit = cur ^ prv;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/lab9_soc_sig_sync.sv
// Purpose: WIDTH x SYNC_STAGES flop-chain synchroniser for asynchronous level signals.
// Latency: SYNC_STAGES clk cycles from async_i to sync_o.
// Backpressure: none; samples every cycle.
// Ports: clk_i/rst_i (async active-high), async_i (raw inputs), sync_o (synchronised outputs).
module lab9_soc_sig_sync #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/lab9_soc_from_hw_sig.sv
// Purpose: Avalon-MM input PIO: synchronises hardware status bits, sticky edge capture, maskable irq.
// Latency: readdata 1 cycle after read strobe; in_port->DATA SYNC_STAGES, in_port->EDGECAP/irq SYNC_STAGES+1.
// Backpressure: none (no waitrequest); back-to-back reads/writes accepted every cycle.
// Ports: clk, reset (async active-high), address/chipselect/read_n/write_n/writedata (slave bus),
//        in_port (async status inputs), readdata (registered read data), irq (level interrupt).
// Build option: define FROM_HW_SIG_IRQ_EN to add the IRQMASK register and drive irq; otherwise irq = 0.
module lab9_soc_from_hw_sig
  import lab9_soc_pio_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] cap_q, cap_d;
  data_word_t       rd_word;
  data_word_t       rdata_q, rdata_d;
  logic             rd_stb, wr_stb;

  // Upper writedata bits are intentionally unused when WIDTH < 32.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign rd_stb = chipselect & ~read_n;
  assign wr_stb = chipselect & ~write_n;

  lab9_soc_sig_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk),
    .rst_i   (reset),
    .async_i (in_port),
    .sync_o  (sync)
  );

`ifdef FROM_HW_SIG_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;
`endif

  always_comb begin
    edge_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_hit[i] = edge_detect(EDGE_SEL, sync[i], prev_q[i]);
    end

    // Write-1-to-clear; a same-cycle edge re-sets the bit so no event is lost.
    clr = '0;
    if (wr_stb && (address == ADDR_EDGECAP)) begin
      clr = writedata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~clr) | edge_hit;

    rd_word = '0;
    case (address)
      ADDR_DATA:    rd_word[WIDTH-1:0] = sync;
`ifdef FROM_HW_SIG_IRQ_EN
      ADDR_IRQMASK: rd_word[WIDTH-1:0] = mask_q;
`endif
      ADDR_EDGECAP: rd_word[WIDTH-1:0] = cap_q;
      default:      rd_word = '0;
    endcase
    // Bus is zero whenever no read is in flight.
    rdata_d = rd_stb ? rd_word : '0;
  end

`ifdef FROM_HW_SIG_IRQ_EN
  always_comb begin
    mask_d = mask_q;
    if (wr_stb && (address == ADDR_IRQMASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    // Computed from next-state so irq rises in the same cycle as the EDGECAP bit.
    irq_d = |(cap_d & mask_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      prev_q  <= sync;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;

endmodule

// File: tb/tb_lab9_soc_from_hw_sig.sv
// Purpose: scoreboard bench for lab9_soc_from_hw_sig; three instances (rise/fall/any edge) share one bus.
// Latency: model predicts every cycle's readdata and irq per instance; monitor compares at negedge.
// Backpressure: n/a.
module tb_lab9_soc_from_hw_sig;

  localparam int W = 2;
  localparam int S = 2;

`ifdef FROM_HW_SIG_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    address;
  logic          chipselect, read_n, write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd0, rd1, rd2;
  logic          irq0, irq1, irq2;

  always #5 clk = ~clk;

  lab9_soc_from_hw_sig #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset(rst), .address(address), .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
  lab9_soc_from_hw_sig #(.WIDTH(W), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_fall (
    .clk(clk), .reset(rst), .address(address), .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
  lab9_soc_from_hw_sig #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset(rst), .address(address), .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

  typedef struct packed {
    logic [2:0][31:0] rd;
    logic [2:0]       irq;
  } exp_t;

  exp_t          exp_q[$];
  logic [W-1:0]  hist[$];          // in_port as sampled at each edge, newest first
  logic [2:0][W-1:0] m_cap;
  logic [W-1:0]  m_mask;
  int            checks = 0;
  int            errors = 0;

  // in_port value sampled j edges ago (0 before reset release).
  function automatic logic [W-1:0] age(input int j);
    return (hist.size() > j) ? hist[j] : '0;
  endfunction

  // Reference model: DATA shows in_port as it was S edges back; an edge is a change
  // between the samples S and S+1 edges back, filtered by each instance's edge type.
  always @(posedge clk) begin : model
    exp_t        e;
    logic [W-1:0] s, p, clr, edg;
    logic        rd, wr;
    logic [31:0] val;
    e = '0;
    if (rst) begin
      hist.delete();
      m_cap  = '0;
      m_mask = '0;
    end else begin
      hist.push_front(in_port);
      if (hist.size() > S + 2) void'(hist.pop_back());
      s   = age(S);
      p   = age(S + 1);
      rd  = chipselect && !read_n;
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int k = 0; k < 3; k++) begin
        case (address)
          2'd0:    val = 32'(s);
          2'd2:    val = IRQ_EN ? 32'(m_mask) : 32'd0;
          2'd3:    val = 32'(m_cap[k]);
          default: val = 32'd0;
        endcase
        e.rd[k] = rd ? val : 32'd0;
        if (k == 0)      edg = s & ~p;
        else if (k == 1) edg = ~s & p;
        else             edg = s ^ p;
        m_cap[k] = (m_cap[k] & ~clr) | edg;
      end
      if (IRQ_EN && wr && address == 2'd2) m_mask = writedata[W-1:0];
      for (int k = 0; k < 3; k++) begin
        e.irq[k] = IRQ_EN ? |(m_cap[k] & m_mask) : 1'b0;
      end
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are registered, so each negedge shows the effect of the preceding edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (rst) e = '0;
    chk("readdata_rise", rd0, e.rd[0]);
    chk("readdata_fall", rd1, e.rd[1]);
    chk("readdata_any",  rd2, e.rd[2]);
    chk("irq_rise", {31'd0, irq0}, {31'd0, e.irq[0]});
    chk("irq_fall", {31'd0, irq1}, {31'd0, e.irq[1]});
    chk("irq_any",  {31'd0, irq2}, {31'd0, e.irq[2]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; read_n = 1'b1; write_n = 1'b0;
    tick();
    bus_idle();
  endtask

  initial begin
    rst = 1'b1; in_port = 2'b01; address = 2'd0; writedata = 32'd0;
    bus_idle();
    idle(3);
    rst = 1'b0;

    // Input held high through reset: DATA=1, one rising capture on bit0.
    idle(S);
    bus_rd(2'd0);
    bus_rd(2'd3);
    idle(2);

    // Interrupt path on bit1.
    bus_wr(2'd2, 32'h2);
    in_port[1] = 1'b1;
    idle(S + 2);
    bus_rd(2'd3);

    // Clear racing a new edge on bit1, then a plain clear.
    in_port[1] = 1'b0;
    idle(6);
    bus_wr(2'd3, 32'h2);
    idle(2);
    in_port[1] = 1'b1;
    idle(S);
    bus_wr(2'd3, 32'h2);
    bus_rd(2'd3);
    bus_wr(2'd3, 32'h2);
    bus_rd(2'd3);
    idle(2);

    // bit0 high->low, clear, low->high.
    in_port[0] = 1'b0;
    idle(5);
    bus_rd(2'd3);
    bus_wr(2'd3, 32'h3);
    in_port[0] = 1'b1;
    idle(5);
    bus_rd(2'd3);

    // Bus hygiene: read-only and reserved writes ignored.
    bus_wr(2'd0, 32'hFFFF_FFFF);
    bus_wr(2'd1, 32'hFFFF_FFFF);
    for (int a = 0; a < 4; a++) bus_rd(2'(a));

    // Mask write then a forced edge (irq stays low without the IRQ build).
    bus_wr(2'd2, 32'h3);
    in_port[0] = 1'b0;
    idle(5);
    bus_rd(2'd2);
    bus_rd(2'd3);

    // Randomised back-to-back traffic with a mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        bus_idle();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      address   = 2'($urandom_range(0, 3));
      writedata = $urandom;
      case ($urandom_range(0, 3))
        0: bus_idle();
        1: begin chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; end
        2: begin chipselect = 1'b1; read_n = 1'b1; write_n = 1'b0; end
        default: begin chipselect = 1'b0; read_n = 1'b0; write_n = 1'b0; end
      endcase
      tick();
    end
    bus_idle();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
